// File: rtl/riscv_wbu_pkg.sv
// Shared types for the multi-channel writeback unit and its round-robin arbiter.
package riscv_wbu_pkg;

    localparam int WB_RF_ADDR_W = 5;
    localparam int WB_PC_W      = 30;
    localparam int WB_DATA_W    = 32;

    typedef struct packed {
        logic [WB_PC_W-1:0]      pc;
        logic [WB_RF_ADDR_W-1:0] rd_addr;
        logic [WB_DATA_W-1:0]    rd_data;
    } wb_entry_t;

    // Index width that stays legal for a single-requester instance.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping at N.
module riscv_rr_arbiter
    import riscv_wbu_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    int k;

    // NOTE: every variable gets a default before the loop, otherwise paths that
    // skip an assignment turn into latches.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        k           = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            for (int j = 0; j < N; j++) begin
                if (!grant_valid && req[j] && (j == k)) begin
                    grant_valid = 1'b1;
                    grant[j]    = 1'b1;
                    grant_idx   = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/riscv_wbu_mc.sv
// Multi-channel writeback unit: one holding entry per producer, round-robin drain
// onto the regfile port. Optional same-cycle bypass when idle: RISCV_WBU_BYPASS_EN.
module riscv_wbu_mc
    import riscv_wbu_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 64
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [NUM_CH-1:0]                valid_i,
    output logic [NUM_CH-1:0]                ready_o,
    input  logic [NUM_CH*WB_PC_W-1:0]        pc_i,
    input  logic [NUM_CH*WB_RF_ADDR_W-1:0]   rd_addr_i,
    input  logic [NUM_CH*WB_DATA_W-1:0]      rd_data_i,
    output logic                             rf_w_enable_o,
    output logic [WB_RF_ADDR_W-1:0]          rf_w_addr_o,
    output logic [WB_DATA_W-1:0]             rf_w_data_o,
    output logic                             retire_valid_o,
    output logic [WB_PC_W-1:0]               retire_pc_o,
    output logic [CNT_W-1:0]                 retire_cnt_o,
    output logic [NUM_CH*WB_RF_ADDR_W-1:0]   hz_rd_addr_o,
    output logic [31:0]                      hz_pending_o
);

    localparam int IW = idx_w(NUM_CH);

    wb_entry_t         entry_q [NUM_CH];
    wb_entry_t         in_ent  [NUM_CH];
    logic [NUM_CH-1:0] occ_q;
    logic [IW-1:0]     rr_ptr_q;
    logic [CNT_W-1:0]  retire_cnt_q;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] capture;
    logic [IW-1:0]     grant_idx;
    logic              grant_valid;
    logic              bypass;
    wb_entry_t         win;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            in_ent[c].pc      = pc_i[c*WB_PC_W +: WB_PC_W];
            in_ent[c].rd_addr = rd_addr_i[c*WB_RF_ADDR_W +: WB_RF_ADDR_W];
            in_ent[c].rd_data = rd_data_i[c*WB_DATA_W +: WB_DATA_W];
        end
    end

    // Reset masks all requests so nothing is written while entries are discarded.
    always_comb begin
        bypass = 1'b0;
        req    = occ_q;
`ifdef RISCV_WBU_BYPASS_EN
        if (occ_q == '0) begin
            bypass = 1'b1;
            req    = valid_i;
        end
`endif
        if (reset_i) req = '0;
    end

    riscv_rr_arbiter #(.N(NUM_CH)) u_arb (
        .req         (req),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        win = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) win = bypass ? in_ent[c] : entry_q[c];
        end
    end

    assign ready_o = ~occ_q | grant;
    // A bypassed input is retired directly and must not also be stored.
    assign capture = valid_i & ready_o & ~(bypass ? grant : '0);

    assign retire_valid_o = grant_valid;
    assign retire_pc_o    = win.pc;
    assign rf_w_addr_o    = win.rd_addr;
    assign rf_w_data_o    = win.rd_data;
    assign rf_w_enable_o  = grant_valid && (win.rd_addr != '0);
    assign retire_cnt_o   = retire_cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            occ_q        <= '0;
            rr_ptr_q     <= '0;
            retire_cnt_q <= '0;
        end else begin
            occ_q <= (occ_q & ~grant) | capture;
            if (grant_valid) begin
                rr_ptr_q     <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + IW'(1);
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: entry payloads are not reset; occ_q qualifies every use of them.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (capture[c]) entry_q[c] <= in_ent[c];
        end
    end

    always_comb begin
        hz_rd_addr_o = '0;
        hz_pending_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (occ_q[c]) begin
                hz_rd_addr_o[c*WB_RF_ADDR_W +: WB_RF_ADDR_W] = entry_q[c].rd_addr;
                hz_pending_o[entry_q[c].rd_addr]             = 1'b1;
            end
        end
        hz_pending_o[0] = 1'b0;
    end

endmodule
